// File: rtl/tcdm_rr_arbiter.sv
// rtl/tcdm_rr_arbiter.sv - round-robin TCDM arbiter with in-order response routing FIFO
// Shares one slave port among NUM_MASTERS masters; responses return via a grant-order FIFO.
module tcdm_rr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*32-1:0]     m_addr,
    input  logic [NUM_MASTERS-1:0]        m_wen,
    input  logic [NUM_MASTERS*32-1:0]     m_wdata,
    input  logic [NUM_MASTERS*4-1:0]      m_be,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [NUM_MASTERS-1:0]        m_r_valid,
    output logic [NUM_MASTERS-1:0]        m_r_opc,
    output logic [NUM_MASTERS*32-1:0]     m_r_rdata,
    output logic                          s_req,
    output logic [31:0]                   s_addr,
    output logic                          s_wen,
    output logic [3:0]                    s_be,
    output logic [31:0]                   s_wdata,
    input  logic                          s_gnt,
    input  logic                          s_r_valid,
    input  logic                          s_r_opc,
    input  logic [31:0]                   s_r_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                          err_unexpected_rsp
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IW-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [IW-1:0] sel;
    logic [IW-1:0] hd;
    logic          found, empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign hd    = fifo_q[rd_q];

    // Search starts at the priority pointer and wraps around the master set.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && m_req[(int'(ptr_q) + k) % NUM_MASTERS]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr_q) + k) % NUM_MASTERS);
            end
        end
    end

    // Full blocks requests even when a pop is pending, keeping s_r_valid off the s_req path.
    assign s_req = found && !full;
    assign push  = s_req && s_gnt;
    assign pop   = s_r_valid && !empty;

    always_comb begin
        s_addr    = '0;
        s_wen     = 1'b0;
        s_be      = '0;
        s_wdata   = '0;
        m_gnt     = '0;
        m_r_valid = '0;
        m_r_opc   = '0;
        m_r_rdata = '0;
        if (s_req) begin
            s_addr  = m_addr[int'(sel)*32 +: 32];
            s_wen   = m_wen[sel];
            s_be    = m_be[int'(sel)*4 +: 4];
            s_wdata = m_wdata[int'(sel)*32 +: 32];
        end
        if (push) begin
            m_gnt[sel] = 1'b1;
        end
        if (pop) begin
            m_r_valid[hd]                  = 1'b1;
            m_r_opc[hd]                    = s_r_opc;
            m_r_rdata[int'(hd)*32 +: 32]   = s_r_rdata;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        fifo_d  = fifo_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        err_d   = s_r_valid && empty;
        if (push) begin
            ptr_d        = (sel == IW'(NUM_MASTERS - 1)) ? '0 : sel + IW'(1);
            fifo_d[wr_q] = sel;
            wr_d         = (wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = (rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            fifo_q  <= fifo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign outstanding        = count_q;
    assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// tb/tb_tcdm_rr_arbiter.sv - directed self-checking bench for tcdm_rr_arbiter
module tb_tcdm_rr_arbiter;

    localparam int N = 4;
    localparam int M = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     m_req;
    logic [N*32-1:0]  m_addr;
    logic [N-1:0]     m_wen;
    logic [N*32-1:0]  m_wdata;
    logic [N*4-1:0]   m_be;
    logic [N-1:0]     m_gnt;
    logic [N-1:0]     m_r_valid;
    logic [N-1:0]     m_r_opc;
    logic [N*32-1:0]  m_r_rdata;
    logic             s_req;
    logic [31:0]      s_addr;
    logic             s_wen;
    logic [3:0]       s_be;
    logic [31:0]      s_wdata;
    logic             s_gnt;
    logic             s_r_valid;
    logic             s_r_opc;
    logic [31:0]      s_r_rdata;
    logic [2:0]       outstanding;
    logic             err_unexpected_rsp;

    int errors = 0;
    int checks = 0;

    tcdm_rr_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_r_valid(m_r_valid), .m_r_opc(m_r_opc), .m_r_rdata(m_r_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_wen(s_wen), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_r_valid(s_r_valid), .s_r_opc(s_r_opc), .s_r_rdata(s_r_rdata),
        .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_req = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_be = '0;
        s_gnt = 1'b0; s_r_valid = 1'b0; s_r_opc = 1'b0; s_r_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_unexpected_rsp); end
        checks++; if (s_req !== 1'b0 || m_gnt !== 4'b0 || m_r_valid !== 4'b0) begin
            errors++; $display("FAIL reset_outputs got s_req=%b gnt=%b rv=%b want 0/0000/0000", s_req, m_gnt, m_r_valid);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_master();
        idle();
        m_req = 4'b0100; m_wen[2] = 1'b1; m_addr[2*32 +: 32] = 32'h100; m_be[2*4 +: 4] = 4'hF;
        s_gnt = 1'b1;
        #1;
        checks++; if (m_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", m_gnt); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_wen !== 1'b1 || s_be !== 4'hF) begin
            errors++; $display("FAIL single_sreq got req=%b addr=%h wen=%b be=%h want 1/00000100/1/f", s_req, s_addr, s_wen, s_be);
        end
        next_cycle();
        idle();
        #1;
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_out1 got %0d want 1", outstanding); end
        next_cycle();
        s_r_valid = 1'b1; s_r_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (m_r_valid !== 4'b0100) begin errors++; $display("FAIL single_rvalid got %b want 0100", m_r_valid); end
        checks++; if (m_r_rdata !== {32'h0, 32'hDEADBEEF, 64'h0}) begin errors++; $display("FAIL single_rdata got %h want deadbeef in lane 2", m_r_rdata); end
        next_cycle();
        idle();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_out0 got %0d want 0", outstanding); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g, exp_r;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            m_req = 4'b1111; s_gnt = 1'b1;
            s_r_valid = (k > 0); s_r_rdata = 32'hA000_0000 + k;
            #1;
            exp_g = 4'b0001 << (k % 4);
            exp_r = (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
            checks++; if (m_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", k, m_gnt, exp_g); end
            checks++; if (m_r_valid !== exp_r) begin errors++; $display("FAIL rr_rsp[%0d] got %b want %b", k, m_r_valid, exp_r); end
            next_cycle();
        end
        idle();
        s_r_valid = 1'b1;
        #1;
        checks++; if (m_r_valid !== 4'b1000) begin errors++; $display("FAIL rr_last_rsp got %b want 1000", m_r_valid); end
        next_cycle();
        idle();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rr_drain got %0d want 0", outstanding); end
    endtask

    task automatic test_full();
        logic [N-1:0] exp_r;
        for (int k = 0; k < 4; k++) begin
            m_req = 4'b1111; s_gnt = 1'b1;
            #1;
            checks++; if (m_gnt !== (4'b0001 << k)) begin errors++; $display("FAIL full_fill_gnt[%0d] got %b want %b", k, m_gnt, 4'b0001 << k); end
            next_cycle();
        end
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", outstanding); end
        checks++; if (s_req !== 1'b0 || m_gnt !== 4'b0) begin errors++; $display("FAIL full_block got s_req=%b gnt=%b want 0/0000", s_req, m_gnt); end
        next_cycle();
        s_r_valid = 1'b1;
        #1;
        checks++; if (s_req !== 1'b0 || m_gnt !== 4'b0) begin errors++; $display("FAIL full_pop_block got s_req=%b gnt=%b want 0/0000", s_req, m_gnt); end
        checks++; if (m_r_valid !== 4'b0001) begin errors++; $display("FAIL full_pop_route got %b want 0001", m_r_valid); end
        next_cycle();
        s_r_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_after_pop got %0d want 3", outstanding); end
        checks++; if (s_req !== 1'b1 || m_gnt !== 4'b0001) begin errors++; $display("FAIL full_reassert got s_req=%b gnt=%b want 1/0001", s_req, m_gnt); end
        next_cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            s_r_valid = 1'b1;
            #1;
            exp_r = (k == 3) ? 4'b0001 : (4'b0010 << k);
            checks++; if (m_r_valid !== exp_r) begin errors++; $display("FAIL full_drain[%0d] got %b want %b", k, m_r_valid, exp_r); end
            next_cycle();
        end
        idle();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", outstanding); end
    endtask

    task automatic test_push_pop();
        idle();
        m_req = 4'b0010; s_gnt = 1'b1;
        next_cycle();
        m_req = 4'b1000;
        next_cycle();
        m_req = 4'b0001; s_r_valid = 1'b1; s_r_opc = 1'b1; s_r_rdata = 32'h55;
        #1;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL pp_pre got %0d want 2", outstanding); end
        checks++; if (m_gnt !== 4'b0001) begin errors++; $display("FAIL pp_gnt got %b want 0001", m_gnt); end
        checks++; if (m_r_valid !== 4'b0010 || m_r_opc !== 4'b0010 || m_r_rdata[63:32] !== 32'h55) begin
            errors++; $display("FAIL pp_route got rv=%b opc=%b rdata1=%h want 0010/0010/00000055", m_r_valid, m_r_opc, m_r_rdata[63:32]);
        end
        next_cycle();
        idle();
        #1;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL pp_count got %0d want 2", outstanding); end
        s_r_valid = 1'b1;
        #1;
        checks++; if (m_r_valid !== 4'b1000) begin errors++; $display("FAIL pp_second got %b want 1000", m_r_valid); end
        next_cycle();
        #1;
        checks++; if (m_r_valid !== 4'b0001) begin errors++; $display("FAIL pp_third got %b want 0001", m_r_valid); end
        next_cycle();
        idle();
    endtask

    task automatic test_unexpected();
        idle();
        s_r_valid = 1'b1;
        #1;
        checks++; if (m_r_valid !== 4'b0) begin errors++; $display("FAIL unexp_rvalid got %b want 0000", m_r_valid); end
        checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL unexp_early got %b want 0", err_unexpected_rsp); end
        next_cycle();
        s_r_valid = 1'b0;
        #1;
        checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL unexp_pulse got %b want 1", err_unexpected_rsp); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL unexp_count got %0d want 0", outstanding); end
        next_cycle();
        #1;
        checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL unexp_clear got %b want 0", err_unexpected_rsp); end
    endtask

    task automatic test_reset_mid();
        idle();
        m_req = 4'b0100; s_gnt = 1'b1;
        for (int k = 0; k < 3; k++) next_cycle();
        idle();
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL rst_pre got %0d want 3", outstanding); end
        rst_n = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_async_count got %0d want 0", outstanding); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL rst_async_ptr got %0d want 0", dut.ptr_q); end
        #1;
        rst_n = 1'b1;
        next_cycle();
        m_req = 4'b1111; s_gnt = 1'b1;
        #1;
        checks++; if (m_gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt got %b want 0001", m_gnt); end
        next_cycle();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single_master();
        test_round_robin();
        test_full();
        test_push_pop();
        test_unexpected();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcdm_rr_arbiter.md
# tcdm_rr_arbiter

Round-robin arbiter that shares one TCDM slave port among `NUM_MASTERS` TCDM master ports. It forwards one granted request per cycle. It records the granting master's index in an in-order response-routing FIFO, so each slave `r_valid` beat returns to the master that issued it. It sits between the core/accelerator TCDM initiators and a single memory bank or peripheral in the cluster interconnect, and speaks the same req/gnt + r_valid protocol on both sides.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of master ports (2..16).
- `MAX_OUTSTANDING`, 4: depth of the response-routing FIFO, i.e. the maximum number of granted requests awaiting `r_valid` (1..16; power of two not required).

Ports:
- `clk`  in  1  single clock, all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_req`  in  NUM_MASTERS  per-master request.
- `m_addr`  in  NUM_MASTERS*32  per-master address, master i at bits [32i+31:32i].
- `m_wen`  in  NUM_MASTERS  per-master write-enable-low (1 = read).
- `m_wdata`  in  NUM_MASTERS*32  per-master write data.
- `m_be`  in  NUM_MASTERS*4  per-master byte enables.
- `m_gnt`  out  NUM_MASTERS  per-master grant, one-hot or zero.
- `m_r_valid`  out  NUM_MASTERS  per-master response valid, one-hot or zero.
- `m_r_opc`  out  NUM_MASTERS  per-master response error flag.
- `m_r_rdata`  out  NUM_MASTERS*32  per-master read data.
- `s_req`, `s_addr[31:0]`, `s_wen`, `s_be[3:0]`, `s_wdata[31:0]`  out: slave request.
- `s_gnt`  in  1  slave grant.
- `s_r_valid`, `s_r_opc`, `s_r_rdata[31:0]`  in: slave response.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  registered count of FIFO entries.
- `err_unexpected_rsp`  out  1  registered one-cycle pulse: `s_r_valid` arrived with the FIFO empty.

## Operation
- Priority pointer `ptr`, range 0..NUM_MASTERS-1, reset 0. Selected master `sel` is the first i with `m_req[i]`=1, searching `ptr`, `ptr+1`, … modulo NUM_MASTERS.
- `s_req = |m_req && !full`. The `s_addr/s_wen/s_wdata/s_be` fields mux from `sel`. When `s_req`=0 they are driven to 0.
- `m_gnt[sel] = s_gnt && s_req`. All other bits are 0.
- Handshake is `s_req && s_gnt`. On a handshake:
  - push `sel` into the FIFO;
  - `ptr <= sel+1` (wrap to 0 after NUM_MASTERS-1).
- Without a handshake, `ptr` holds. While a master waits, `sel` may change only if a higher-priority master raises `m_req`. This is legal, because the slave samples only on `s_gnt`.
- Response routing is purely combinational from the FIFO head `hd`:
  - `m_r_valid[hd] = s_r_valid && !empty`;
  - `m_r_opc[hd]` and `m_r_rdata[hd]` come from the slave;
  - all other masters get 0.
- `s_r_valid` pops the FIFO.
- Simultaneous push and pop: `outstanding` is unchanged and FIFO order is preserved.
- Full (`outstanding == MAX_OUTSTANDING`): `s_req` is forced to 0 and all `m_gnt` are 0, even if a pop occurs in the same cycle. There is no combinational `s_r_valid`→`s_req` path.
- `s_r_valid` with the FIFO empty:
  - no `m_r_valid` asserted;
  - FIFO and count unchanged (no underflow);
  - `err_unexpected_rsp` pulses the next cycle.
- A slave response must arrive at least one cycle after its grant. A same-cycle response to a request granted from an empty FIFO is flagged as unexpected.
- Fairness: with all masters requesting continuously and no stalls, each master is granted exactly once per NUM_MASTERS handshakes.

## Timing
- Request path (m_* → s_*, s_gnt → m_gnt) and response path (s_r_* → m_r_*) are zero-latency combinational.
- `ptr`, FIFO, `outstanding` and `err_unexpected_rsp` are registered; updates are visible the cycle after the event.
- Reset values:
  - `ptr`=0, FIFO empty, `outstanding`=0, `err_unexpected_rsp`=0;
  - consequently `s_req`=0, `m_gnt`=0 and `m_r_valid`=0 while `m_req`=0.
- Reset asserted mid-transaction: FIFO contents are discarded immediately. Responses arriving afterwards are treated as unexpected.
- Maximum throughput is one grant per cycle when the slave holds `s_gnt`=1 and responses drain at least as fast as grants.

## Test plan
- **Single master:** master 2 reads addr 0x100; slave grants in cycle 0 and returns rdata 0xDEADBEEF in cycle 2.
  - Required: `m_gnt`=0b0100 in cycle 0.
  - Required: `m_r_valid`=0b0100 with rdata 0xDEADBEEF in cycle 2; `outstanding` goes 0→1→0.
- **Round-robin:** all 4 masters request continuously, `s_gnt`=1, responses one cycle after each grant.
  - Required grant order: 0,1,2,3,0,1,…
  - Required: each response is routed to the master granted one cycle earlier.
- **Full:** MAX_OUTSTANDING=4, slave grants 4 requests and withholds responses.
  - Required: the 5th cycle has `s_req`=0 and `m_gnt`=0, `outstanding`=4.
  - Required: one `s_r_valid` drops the count to 3, and `s_req` reasserts the following cycle.
- **Simultaneous push/pop:** with `outstanding`=2, a grant and a response occur in the same cycle.
  - Required: `outstanding` stays 2.
  - Required: the response goes to the oldest entry.
- **Unexpected response:** `s_r_valid`=1 with the FIFO empty.
  - Required: no `m_r_valid`; `err_unexpected_rsp`=1 for exactly one cycle; `outstanding` stays 0.
- **Reset mid-operation:** with `outstanding`=3, `rst_n` is pulsed low asynchronously.
  - Required: `outstanding`=0 and `ptr`=0 immediately.
  - Required: after release, master 0 wins when all masters request.
